// File: rtl/wbmem_pkg.sv
// wbmem_pkg: shared constants and state encoding for the weights-memory loader.
//   N_HID/N_OUT  : layer-1 / layer-2 bank counts (42 banks in total)
//   DEPTH1/2     : words per bank in each layer (weights + bias)
//   TOTAL_WORDS  : stream length of one complete weight set
package wbmem_pkg;

    localparam int N_HID       = 32;
    localparam int N_OUT       = 10;
    localparam int DEPTH1      = 785;
    localparam int DEPTH2      = 33;
    localparam int N_BANKS     = N_HID + N_OUT;
    localparam int TOTAL_WORDS = N_HID * DEPTH1 + N_OUT * DEPTH2;
    localparam int AW          = 10;
    localparam int DW          = 32;
    localparam int BANK_W      = 6;

    typedef enum logic [2:0] {
        IDLE,
        L1,
        L2,
        CSUM,
        DONE
    } ld_state_e;

endpackage

// File: rtl/wbmem_addr_gen.sv
// wbmem_addr_gen: bank/word-address counter pair for the weight loader.
//   load_i/load_bank_i : restart at (load_bank_i, addr 0); wins over step_i
//   step_i             : advance one word; addr wraps at limit_i and bumps bank
//   limit_i            : last word address of a bank in the current layer
//   bank_last_i        : last bank of the current layer
//   bank_o/addr_o      : current position
//   last_o             : current position is the final word of the layer
module wbmem_addr_gen #(
    parameter int AW = 10,
    parameter int BW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic [BW-1:0] load_bank_i,
    input  logic          step_i,
    input  logic [AW-1:0] limit_i,
    input  logic [BW-1:0] bank_last_i,
    output logic [BW-1:0] bank_o,
    output logic [AW-1:0] addr_o,
    output logic          last_o
);

    logic [BW-1:0] bank_q, bank_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          wrap;

    assign wrap   = (addr_q == limit_i);
    assign last_o = wrap && (bank_q == bank_last_i);
    assign bank_o = bank_q;
    assign addr_o = addr_q;

    always_comb begin
        bank_d = bank_q;
        addr_d = addr_q;
        if (load_i) begin
            bank_d = load_bank_i;
            addr_d = '0;
        end else if (step_i) begin
            if (wrap) begin
                addr_d = '0;
                bank_d = bank_q + 1'b1;
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_q <= '0;
            addr_q <= '0;
        end else begin
            bank_q <= bank_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/wbmem_loader.sv
// wbmem_loader: turns the [W1|b1][W2|b2] word stream from the CPU bridge into
// single-cycle writes on the 42 weight-bank write ports (banks 0..31 layer 1,
// banks 32..41 layer 2), stream order bank-major within each layer.
//   start            : begin a load (only looked at in IDLE)
//   s_valid/s_data   : stream word; s_ready is high while a layer is loading
//   wr_en/wr_bank/wr_addr/wr_data : registered write, one cycle after handshake
//   busy/done/loaded : load in progress / completion pulse / weight set valid
// Optional build macro WBMEM_LOADER_CHECKSUM_EN: one extra stream word after
// the last weight is compared against a 32-bit wrap-around sum of all weight
// words; a mismatch leaves loaded=0 and raises csum_err.
module wbmem_loader #(
    parameter int N_HID  = wbmem_pkg::N_HID,
    parameter int N_OUT  = wbmem_pkg::N_OUT,
    parameter int DEPTH1 = wbmem_pkg::DEPTH1,
    parameter int DEPTH2 = wbmem_pkg::DEPTH2,
    parameter int AW     = wbmem_pkg::AW,
    parameter int DW     = wbmem_pkg::DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          wr_en,
    output logic [5:0]    wr_bank,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          busy,
    output logic          done,
    output logic          loaded
`ifdef WBMEM_LOADER_CHECKSUM_EN
    ,
    output logic          csum_err
`endif
);
    import wbmem_pkg::*;

    ld_state_e     state_q;
    logic          in_layer, hs, wr_hs;
    logic          ag_load, ag_last;
    logic [5:0]    ag_bank, ag_load_bank, ag_bank_last;
    logic [AW-1:0] ag_addr, ag_limit;

    assign in_layer = (state_q == L1) || (state_q == L2);
`ifdef WBMEM_LOADER_CHECKSUM_EN
    logic [DW-1:0] sum_q;
    assign s_ready = in_layer || (state_q == CSUM);
`else
    assign s_ready = in_layer;
`endif
    assign hs    = s_valid && s_ready;
    // Only weight words reach the banks; a checksum word is consumed silently.
    assign wr_hs = hs && in_layer;

    // The counter is reloaded twice per load: at start (bank 0) and when the
    // last layer-1 word is taken (bank N_HID).
    assign ag_load      = ((state_q == IDLE) && start) || ((state_q == L1) && wr_hs && ag_last);
    assign ag_load_bank = (state_q == IDLE) ? 6'd0 : 6'(N_HID);
    assign ag_limit     = (state_q == L1) ? AW'(DEPTH1 - 1) : AW'(DEPTH2 - 1);
    assign ag_bank_last = (state_q == L1) ? 6'(N_HID - 1) : 6'(N_HID + N_OUT - 1);

    wbmem_addr_gen #(.AW(AW), .BW(6)) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .load_i     (ag_load),
        .load_bank_i(ag_load_bank),
        .step_i     (wr_hs),
        .limit_i    (ag_limit),
        .bank_last_i(ag_bank_last),
        .bank_o     (ag_bank),
        .addr_o     (ag_addr),
        .last_o     (ag_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_en    <= 1'b0;
            wr_bank  <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            loaded   <= 1'b0;
`ifdef WBMEM_LOADER_CHECKSUM_EN
            sum_q    <= '0;
            csum_err <= 1'b0;
`endif
        end else begin
            wr_en <= wr_hs;
            done  <= 1'b0;
            if (wr_hs) begin
                wr_bank <= ag_bank;
                wr_addr <= ag_addr;
                wr_data <= s_data;
            end
`ifdef WBMEM_LOADER_CHECKSUM_EN
            if (wr_hs) sum_q <= sum_q + s_data;
`endif
            case (state_q)
                IDLE: if (start) begin
                    state_q <= L1;
                    busy    <= 1'b1;
                    loaded  <= 1'b0;
`ifdef WBMEM_LOADER_CHECKSUM_EN
                    sum_q    <= '0;
                    csum_err <= 1'b0;
`endif
                end
                L1: if (wr_hs && ag_last) state_q <= L2;
                L2: if (wr_hs && ag_last) begin
`ifdef WBMEM_LOADER_CHECKSUM_EN
                    state_q <= CSUM;
`else
                    state_q <= DONE;
                    done    <= 1'b1;
                    loaded  <= 1'b1;
                    busy    <= 1'b0;
`endif
                end
`ifdef WBMEM_LOADER_CHECKSUM_EN
                CSUM: if (hs) begin
                    state_q  <= DONE;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    loaded   <= (s_data == sum_q);
                    csum_err <= (s_data != sum_q);
                end
`endif
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wbmem_loader.sv
// tb_wbmem_loader: directed test of the weight-bank loader. Three loads: a
// back-to-back full load (with a stray start at word 100), a full load with
// random stalls (start held in the DONE cycle), and a load reset at word 15000
// followed by a fresh start. A negedge monitor records every bank write and
// flags any write not preceded by a weight-word handshake.
module tb_wbmem_loader;

    localparam int NW  = 25450;
    localparam int L1W = 25120;
    localparam int D1  = 785;
    localparam int D2  = 33;
    localparam logic [31:0] SUM_OK = 32'd323838525;  // 0+1+...+25449

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_ready, wr_en, busy, done, loaded;
    logic [5:0]  wr_bank;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
`ifdef WBMEM_LOADER_CHECKSUM_EN
    logic        csum_err;
`endif

    always #5 clk = ~clk;

    wbmem_loader dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .wr_en   (wr_en),
        .wr_bank (wr_bank),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .loaded  (loaded)
`ifdef WBMEM_LOADER_CHECKSUM_EN
        ,
        .csum_err(csum_err)
`endif
    );

    typedef struct { int bank; int addr; int data; int cyc; } wr_t;
    typedef struct { int idx; int bank; int addr; } vec_t;

    wr_t  wq[$];
    int   cyc = 0;
    int   done_cnt = 0;
    int   gap_err = 0;
    logic prev_hs = 1'b0;
    logic sending_csum = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // A write is expected exactly when the previous cycle had a weight-word
    // handshake outside reset.
    always @(negedge clk) begin
        if (wr_en !== prev_hs) gap_err <= gap_err + 1;
        if (wr_en === 1'b1) wq.push_back(wr_t'{int'(wr_bank), int'(wr_addr), int'(wr_data), cyc});
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        prev_hs <= !reset && s_valid && s_ready && !sending_csum;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    function automatic int eb(input int i);
        return (i < L1W) ? i / D1 : 32 + (i - L1W) / D2;
    endfunction
    function automatic int ea(input int i);
        return (i < L1W) ? i % D1 : (i - L1W) % D2;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one word (optionally after random idle cycles) and return just
    // after the edge on which it was accepted.
    task automatic send_word(input logic [31:0] d, input bit stall);
        int g = 0;
        if (stall) begin
            while ($urandom_range(1) == 0 && g < 20) begin
                s_valid = 1'b0;
                tick();
                g++;
            end
        end
        g = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && g < 8) begin
            tick();
            g++;
        end
        if (!s_ready) chk("ready_timeout", 0, 1);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic chk_seq(input string nm, input int base, input int n);
        int bad = 0;
        chk({nm, "_count"}, wq.size() - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i >= wq.size()) bad++;
            else if (wq[base+i].bank != eb(i) || wq[base+i].addr != ea(i) || wq[base+i].data != i) bad++;
        end
        chk({nm, "_seq_errors"}, bad, 0);
    endtask

    vec_t tbl[10];
    int   base, d0;

    initial begin
        tbl[0] = '{0,     0,  0};
        tbl[1] = '{100,   0,  100};
        tbl[2] = '{101,   0,  101};
        tbl[3] = '{784,   0,  784};
        tbl[4] = '{785,   1,  0};
        tbl[5] = '{15000, 19, 85};
        tbl[6] = '{25119, 31, 784};
        tbl[7] = '{25120, 32, 0};
        tbl[8] = '{25153, 33, 0};
        tbl[9] = '{25449, 41, 32};

        // ---- reset state
        repeat (2) tick();
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_bank", wr_bank, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_loaded", loaded, 0);
        chk("rst_s_ready", s_ready, 0);
        reset = 1'b0;
        tick();
        chk("idle_s_ready", s_ready, 0);

        // ---- run A: full load, no stalls, stray start at word 100
        base = wq.size();
        d0 = done_cnt;
        do_start();
        chk("A_busy", busy, 1);
        chk("A_s_ready", s_ready, 1);
        chk("A_loaded_clr", loaded, 0);
        for (int i = 0; i < NW; i++) begin
            if (i == 100) start = 1'b1;
            send_word(i, 1'b0);
            start = 1'b0;
            if (i == 100) chk("A_busy_after_start", busy, 1);
        end
`ifdef WBMEM_LOADER_CHECKSUM_EN
        chk("A_csum_s_ready", s_ready, 1);
        sending_csum = 1'b1;
        send_word(SUM_OK, 1'b0);
        sending_csum = 1'b0;
        chk("A_csum_err", csum_err, 0);
`endif
        chk("A_done", done, 1);
        chk("A_busy_done", busy, 0);
        chk("A_loaded", loaded, 1);
        tick();
        chk("A_done_pulse", done, 0);
        tick();
        chk("A_loaded_hold", loaded, 1);
        chk("A_done_count", done_cnt - d0, 1);
        chk_seq("A", base, NW);
        for (int k = 0; k < 10; k++) begin
            if (base + tbl[k].idx < wq.size()) begin
                chk($sformatf("A_bank_w%0d", tbl[k].idx), wq[base+tbl[k].idx].bank, tbl[k].bank);
                chk($sformatf("A_addr_w%0d", tbl[k].idx), wq[base+tbl[k].idx].addr, tbl[k].addr);
                chk($sformatf("A_data_w%0d", tbl[k].idx), wq[base+tbl[k].idx].data, tbl[k].idx);
            end else begin
                chk($sformatf("A_missing_w%0d", tbl[k].idx), 0, 1);
            end
        end
        // layer boundary: consecutive cycles, no gap or duplicate
        if (base + L1W < wq.size())
            chk("A_boundary_cycles", wq[base+L1W].cyc - wq[base+L1W-1].cyc, 1);
        else
            chk("A_boundary_missing", 0, 1);

        // ---- run B: full load with random stalls, start held in DONE cycle
        base = wq.size();
        d0 = done_cnt;
        do_start();
        chk("B_loaded_clr", loaded, 0);
        for (int i = 0; i < NW; i++) send_word(i, 1'b1);
`ifdef WBMEM_LOADER_CHECKSUM_EN
        sending_csum = 1'b1;
        send_word(SUM_OK + 32'd1, 1'b1);
        sending_csum = 1'b0;
        chk("B_csum_err", csum_err, 1);
        chk("B_loaded", loaded, 0);
`else
        chk("B_loaded", loaded, 1);
`endif
        chk("B_done", done, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("B_idle_busy", busy, 0);
        chk("B_idle_s_ready", s_ready, 0);
        tick();
        chk("B_no_restart", busy, 0);
        chk("B_done_count", done_cnt - d0, 1);
        chk_seq("B", base, NW);

        // ---- run C: reset during the load, then restart
        base = wq.size();
        do_start();
        for (int i = 0; i <= 15000; i++) send_word(i, 1'b0);
        s_valid = 1'b1;
        s_data  = 32'd15001;
        reset   = 1'b1;
        tick();
        s_valid = 1'b0;
        reset   = 1'b0;
        chk("C_wr_en", wr_en, 0);
        chk("C_busy", busy, 0);
        chk("C_loaded", loaded, 0);
        chk("C_s_ready", s_ready, 0);
        tick();
        chk_seq("C", base, 15001);
        base = wq.size();
        do_start();
        send_word(32'h55, 1'b0);
        tick();
        chk("C2_count", wq.size() - base, 1);
        if (wq.size() > base) begin
            chk("C2_bank", wq[base].bank, 0);
            chk("C2_addr", wq[base].addr, 0);
            chk("C2_data", wq[base].data, 32'h55);
        end

        chk("write_timing_errors", gap_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
